// File: rtl/seqdiv_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and the iteration count of the DIV phase.
package seqdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // One restoring iteration per quotient bit.
    function automatic int div_cycles(input int width);
        return width;
    endfunction

    localparam int DIV_CYCLES = div_cycles(DEFAULT_WIDTH);

endpackage

// File: rtl/sequential_divider_if.sv
// Request/result bundle of the sequential divider. The requester drives
// start and operands; the divider returns status and registered results.
interface sequential_divider_if
    import seqdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor and
// keep the difference only when it does not go negative.
module div_step
    import seqdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH:0]   divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= divisor_mag);
    // The kept remainder is always below divisor_mag <= 2^(WIDTH-1), so the
    // top bit can be dropped safely.
    assign rem_out = q_bit ? WIDTH'(shifted - divisor_mag) : WIDTH'(shifted);

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle truncating signed divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor. Works on magnitudes with one restoring step per cycle and applies
// the signs, divide-by-zero and overflow handling in a final FIX cycle.
module sequential_divider
    import seqdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sequential_divider_if.slave   bus
);

    localparam int ITERATIONS = div_cycles(WIDTH);
    localparam int CNT_W      = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    state_t state;
    state_t next_state;
    logic   load;
    logic   finish;

    logic [CNT_W-1:0]   iter_count;
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   work;
    logic [WIDTH:0]     divisor_mag;
    logic [WIDTH-1:0]   dividend_low;
    logic               sign_dividend;
    logic               sign_divisor;
    logic               zero_divisor;
    logic               pre_overflow;

    logic [2*WIDTH-1:0] dividend_mag_in;
    logic [WIDTH:0]     divisor_ext;
    logic [WIDTH:0]     divisor_mag_in;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    logic               result_neg;
    logic               final_overflow;
    logic [WIDTH-1:0]   signed_q;
    logic [WIDTH-1:0]   signed_r;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               div_by_zero_q;
    logic               overflow_q;

    // Operand magnitudes; extra width lets the most-negative values negate without wrapping.
    always_comb begin
        divisor_ext     = {bus.divisor[WIDTH-1], bus.divisor};
        dividend_mag_in = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
        divisor_mag_in  = bus.divisor[WIDTH-1] ? -divisor_ext : divisor_ext;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = DIV;
                    load       = 1'b1;
                end
            end
            DIV: begin
                if (iter_count == LAST_ITER) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
                finish     = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in      (part_rem),
        .bit_in      (work[WIDTH-1]),
        .divisor_mag (divisor_mag),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    // Operand capture on accept, then one restoring iteration per DIV cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_count    <= '0;
            part_rem      <= '0;
            work          <= '0;
            divisor_mag   <= '0;
            dividend_low  <= '0;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
            zero_divisor  <= 1'b0;
            pre_overflow  <= 1'b0;
        end else if (load) begin
            iter_count    <= '0;
            part_rem      <= dividend_mag_in[2*WIDTH-1:WIDTH];
            work          <= dividend_mag_in[WIDTH-1:0];
            divisor_mag   <= divisor_mag_in;
            dividend_low  <= bus.dividend[WIDTH-1:0];
            sign_dividend <= bus.dividend[2*WIDTH-1];
            sign_divisor  <= bus.divisor[WIDTH-1];
            zero_divisor  <= (bus.divisor == '0);
            pre_overflow  <= ({1'b0, dividend_mag_in[2*WIDTH-1:WIDTH]} >= divisor_mag_in);
        end else if (state == DIV) begin
            iter_count    <= iter_count + CNT_W'(1);
            part_rem      <= step_rem;
            work          <= {work[WIDTH-2:0], step_q};
        end
    end

    // Sign restoration and the final range check on the magnitude quotient.
    always_comb begin
        result_neg     = sign_dividend ^ sign_divisor;
        final_overflow = pre_overflow |
                         (result_neg ? (work > MOST_NEG) : (work > MOST_POS));
        signed_q       = result_neg ? -work : work;
        signed_r       = sign_dividend ? -part_rem : part_rem;
    end

    // Registered status and results; results hold until the next FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= finish;
            if (finish) begin
                if (zero_divisor) begin
                    quotient_q    <= '1;
                    remainder_q   <= dividend_low;
                    div_by_zero_q <= 1'b1;
                    overflow_q    <= 1'b0;
                end else if (final_overflow) begin
                    quotient_q    <= MOST_NEG;
                    remainder_q   <= '0;
                    div_by_zero_q <= 1'b0;
                    overflow_q    <= 1'b1;
                end else begin
                    quotient_q    <= signed_q;
                    remainder_q   <= signed_r;
                    div_by_zero_q <= 1'b0;
                    overflow_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider at WIDTH=32: signed results, flags,
// latency, start handling and reset abort, with hand-computed expectations.
module tb_sequential_divider;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;

    int checks_total;
    int checks_passed;

    sequential_divider_if #(.WIDTH(WIDTH)) bus ();

    sequential_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".busy"},        64'(bus.busy),        64'd0);
        check_output({tag, ".done"},        64'(bus.done),        64'd0);
        check_output({tag, ".quotient"},    64'(bus.quotient),    64'd0);
        check_output({tag, ".remainder"},   64'(bus.remainder),   64'd0);
        check_output({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
        check_output({tag, ".overflow"},    64'(bus.overflow),    64'd0);
    endtask

    // One operation from a start pulse in cycle 0 to the cycle after done.
    task automatic apply_stimulus(input string tag, input logic [63:0] dvd,
                                  input logic [31:0] dvs, input logic [31:0] exp_q,
                                  input logic [31:0] exp_r, input logic exp_dz,
                                  input logic exp_ov);
        int cyc;
        int busy_cycles;
        bit seen;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = $urandom;
        cyc = 1;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && cyc <= 60) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cycles++;
                tick();
                cyc++;
            end
        end
        check_output({tag, ".done_cycle"},  64'(cyc),             64'd34);
        check_output({tag, ".busy_cycles"}, 64'(busy_cycles),     64'd33);
        check_output({tag, ".busy_at_done"}, 64'(bus.busy),       64'd0);
        check_output({tag, ".quotient"},    64'(bus.quotient),    64'(exp_q));
        check_output({tag, ".remainder"},   64'(bus.remainder),   64'(exp_r));
        check_output({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dz));
        check_output({tag, ".overflow"},    64'(bus.overflow),    64'(exp_ov));
        tick();
        check_output({tag, ".done_pulse"},  64'(bus.done),        64'd0);
        check_output({tag, ".hold_q"},      64'(bus.quotient),    64'(exp_q));
    endtask

    // Directed sequence.
    initial begin
        int done_count;
        int d1;
        int d2;
        logic [31:0] q1;
        logic [31:0] r1;
        logic [31:0] q2;
        logic [31:0] r2;

        checks_total  = 0;
        checks_passed = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        $display("[TB] signed division vectors");
        apply_stimulus("div_100_7",  64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        apply_stimulus("div_m7_2",   64'hFFFF_FFFF_FFFF_FFF9, 32'd2,
                       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        apply_stimulus("div_7_m2",   64'd7, 32'hFFFF_FFFE,
                       32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        apply_stimulus("ovf_pos",    64'h0000_0001_0000_0000, 32'd2,
                       32'h8000_0000, 32'd0, 1'b0, 1'b1);
        apply_stimulus("neg_limit",  64'hFFFF_FFFF_0000_0000, 32'd2,
                       32'h8000_0000, 32'd0, 1'b0, 1'b0);
        apply_stimulus("div_zero",   64'h1234, 32'd0,
                       32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
        apply_stimulus("most_neg",   64'h8000_0000_0000_0000, 32'h8000_0000,
                       32'h8000_0000, 32'd0, 1'b0, 1'b1);
        apply_stimulus("m2p31_m1",   64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF,
                       32'h8000_0000, 32'd0, 1'b0, 1'b1);
        apply_stimulus("m2p31_1",    64'hFFFF_FFFF_8000_0000, 32'd1,
                       32'h8000_0000, 32'd0, 1'b0, 1'b0);
        apply_stimulus("neg_divisor", 64'h4000_0000, 32'h8000_0000,
                       32'd0, 32'h4000_0000, 1'b0, 1'b0);

        $display("[TB] start while busy");
        bus.dividend = 64'd1000;
        bus.divisor  = 32'd10;
        bus.start    = 1'b1;
        tick();
        bus.start  = 1'b0;
        done_count = 0;
        d1 = 0;
        q1 = '0;
        for (int c = 1; c <= 75; c++) begin
            bus.start = (c >= 5 && c <= 10);
            if (c == 5) begin
                bus.dividend = 64'd9;
                bus.divisor  = 32'd3;
            end
            if (bus.done) begin
                done_count++;
                if (done_count == 1) begin
                    d1 = c;
                    q1 = bus.quotient;
                end
            end
            tick();
        end
        bus.start = 1'b0;
        check_output("ignore.done_count", 64'(done_count), 64'd1);
        check_output("ignore.done_cycle", 64'(d1),         64'd34);
        check_output("ignore.quotient",   64'(q1),         64'd100);

        $display("[TB] start held through done");
        bus.dividend = 64'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        tick();
        done_count = 0;
        d1 = 0; d2 = 0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 90; c++) begin
            if (c == 1) begin
                bus.dividend = 64'hFFFF_FFFF_FFFF_FF9C;
                bus.divisor  = 32'd7;
            end
            bus.start = (c <= 34);
            if (bus.done) begin
                done_count++;
                if (done_count == 1) begin
                    d1 = c; q1 = bus.quotient; r1 = bus.remainder;
                end else if (done_count == 2) begin
                    d2 = c; q2 = bus.quotient; r2 = bus.remainder;
                end
            end
            tick();
        end
        bus.start = 1'b0;
        check_output("b2b.done_count", 64'(done_count), 64'd2);
        check_output("b2b.first_done", 64'(d1),         64'd34);
        check_output("b2b.second_done", 64'(d2),        64'd68);
        check_output("b2b.q1",         64'(q1),         64'd14);
        check_output("b2b.r1",         64'(r1),         64'd2);
        check_output("b2b.q2",         64'(q2),         64'hFFFF_FFF2);
        check_output("b2b.r2",         64'(r2),         64'hFFFF_FFFE);

        $display("[TB] reset mid-operation");
        bus.dividend = 64'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        check_output("abort.busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        bus.start = 1'b1;
        tick();
        check_output("abort.rst_over_start", 64'(bus.busy), 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        done_count = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_count++;
            tick();
        end
        check_output("abort.no_done", 64'(done_count), 64'd0);
        apply_stimulus("after_reset", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
